uart_rx_axis: RTL and testbench
===============================

// Module: uart_rx_axis
// PURPOSE
//  UART receiver; the far end of the team's 8N1 serial link. Oversamples rxd,
//  recovers start/data/stop bits and presents each byte on an AXI-Stream master
//  port. Consumed by top on its rx_i pin; pairs with uart_tx in the runner bench.
//  Flags framing and overrun errors as 1-cycle pulses.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, LSB first, 1 start bit, 1 stop bit, no parity
// PORTS
//  clk            in   1           system clock, all logic on posedge
//  rst            in   1           synchronous, active-high reset
//  rxd            in   1           serial input, idles high, asynchronous to clk
//  prescale       in   16          clk cycles per bit = prescale*8
//  m_axis_tdata   out  DATA_WIDTH  received byte
//  m_axis_tvalid  out  1           tdata holds an unconsumed byte
//  m_axis_tready  in   1           downstream accept
//  busy           out  1           frame reception in progress
//  overrun_error  out  1           1-cycle pulse: new byte overwrote an unconsumed byte
//  frame_error    out  1           1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  - Reset: tdata=0, tvalid=0, busy=0, both error pulses 0, FSM=IDLE,
//    synchroniser flops=1. Reset mid-frame aborts the frame; nothing is output.
//  - rxd passes through a 2-flop synchroniser (rxs) before use: 2 cycles latency.
//  - prescale is captured into an internal register on start detection and held
//    for the whole frame; prescale==0 is treated as 1. BIT = 8*prescale_q.
//  - FSM states: IDLE, START, DATA, STOP, BREAK.
//    IDLE : rxs==0 -> START, counter=BIT/2-1, busy=1 on the next cycle.
//    START: counter==0 -> if rxs==0, DATA (counter=BIT-1, bit_idx=0);
//           else IDLE (glitch rejected, no error flag).
//    DATA : counter==0 -> shift rxs into MSB of shreg (shift right), counter=BIT-1;
//           after DATA_WIDTH samples -> STOP.
//    STOP : counter==0 -> if rxs==1: load tdata=shreg, tvalid=1 next cycle, -> IDLE.
//           If rxs==0: frame_error pulse, byte discarded, -> BREAK.
//    BREAK: wait for rxs==1 -> IDLE (no false start on a held-low line).
//  - busy=1 in every state except IDLE.
//  - Samples are taken mid-bit: start at BIT/2, each data/stop bit BIT later.
//  - Handshake: byte transfers on tvalid&&tready. tvalid stays high and tdata
//    stable until accepted. tvalid never depends combinationally on tready.
//  - Overrun: if a new byte completes while tvalid==1 and tready==0, tdata is
//    overwritten, tvalid stays 1, and overrun_error pulses for that cycle. If
//    tready==1 in that same cycle, the old byte is accepted, the new one is
//    loaded, and no overrun is flagged.
//  - A stop bit ends at the sample point; IDLE may detect the next start on the
//    following cycle, so back-to-back frames need no extra idle time.
// TESTING
//  (prescale=1, i.e. 8 clk/bit; driver is uart_tx with the same prescale.)
//  1. Send 0xA5, tready=1 -> tvalid 1 cycle, tdata=0xA5, busy low after stop,
//     no error pulses.
//  2. Send 0x00 then 0xFF back-to-back, tready=1 -> two transfers, 0x00 then
//     0xFF, in order.
//  3. Drive rxd low for 3 clk, then high -> no tvalid, no frame_error, busy
//     returns to 0.
//  4. Hand-drive a frame of 0x3C with stop bit=0 -> frame_error pulse,
//     tvalid stays 0, FSM waits in BREAK until rxd=1.
//  5. tready=0; send 0x11 then 0x22 -> overrun_error pulses once, tdata=0x22;
//     raise tready -> one transfer of 0x22.
//  6. Assert rst during bit 4 of a frame -> all outputs at reset values; the
//     next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver with an AXI-Stream master output.
// rxd is synchronised, oversampled at 8*prescale clk per bit, sampled mid-bit,
// and each completed byte is held on m_axis_* until the consumer accepts it.
// Framing and overrun errors are reported as single-cycle pulses.
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  // Counter must hold 8*65535-1.
  localparam int CW = 19;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                  rxs_meta;
  logic                  rxs;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]           presc_q, presc_d;
  logic                  load_byte;
  logic                  frame_err_d;

  logic [15:0]           presc_eff;
  logic [CW-1:0]         half_len;
  logic [CW-1:0]         bit_len;
  logic [DATA_WIDTH:0]   shift_tmp;

  // A prescale of zero would never advance; treat it as one.
  assign presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  // Half a bit, minus one, so the start bit is checked at its centre.
  assign half_len  = {1'b0, presc_eff, 2'b00} - CW'(1);
  assign bit_len   = {presc_q, 3'b000};
  assign shift_tmp = {rxs, shreg_q};
  assign busy      = (state_q != S_IDLE);

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser to one flop.
    if (rst) begin
      rxs_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxs_meta <= rxd;
      rxs      <= rxs_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      presc_q   <= 16'd1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      presc_q   <= presc_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame validation.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    presc_d     = presc_q;
    load_byte   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = half_len;
          presc_d = presc_eff;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs) begin
          state_d   = S_DATA;
          cnt_d     = bit_len - CW'(1);
          bit_idx_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shreg_d = shift_tmp[DATA_WIDTH:1];
          cnt_d   = bit_len - CW'(1);
          if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs) begin
          load_byte = 1'b1;
          state_d   = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register, stream handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= frame_err_d;
      if (load_byte) begin
        m_axis_tdata  <= shreg_q;
        m_axis_tvalid <= 1'b1;
        overrun_error <= m_axis_tvalid && !m_axis_tready;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: drives 8N1 frames bit by bit at a chosen prescale and
// compares the accepted byte stream and error pulses with an expected queue.
module tb_uart_rx_axis;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [15:0] prescale;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       overrun_error;
  logic       frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int tvalid_cycles;
  int ovr_cnt;
  int fe_cnt;

  uart_rx_axis #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle: record transfers and error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid) begin
        tvalid_cycles++;
        if (m_axis_tready) rx_q.push_back(m_axis_tdata);
      end
      if (overrun_error) ovr_cnt++;
      if (frame_error) fe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    exp_q.delete();
    tvalid_cycles = 0;
    ovr_cnt       = 0;
    fe_cnt        = 0;
  endtask

  // One frame: start, 8 data bits LSB first, stop bit of the given level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
    int bl;
    bl = 8 * ((p == 0) ? 1 : p);
    prescale = 16'(p);
    rxd = 1'b0;
    tick(bl);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(bl);
    end
    rxd = stop;
    tick(bl);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(4);
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check(tag, rx_q[i], exp_q[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    prescale = 16'd1;
    m_axis_tready = 1'b1;
    clear_obs();
    tick(3);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_error, 0);
    check("rst_fe", frame_error, 0);
    rst = 1'b0;
    tick(5);

    // Single byte, always ready.
    clear_obs();
    send_frame(8'hA5, 1'b1, 1);
    exp_q.push_back(8'hA5);
    wait_rx(1, 100);
    compare_stream("t1_data");
    check("t1_tvalid_cycles", tvalid_cycles, 1);
    check("t1_busy", busy, 0);
    check("t1_ovr", ovr_cnt, 0);
    check("t1_fe", fe_cnt, 0);

    // Back-to-back frames with no idle gap.
    clear_obs();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wait_rx(2, 100);
    compare_stream("t2_data");
    check("t2_fe", fe_cnt, 0);

    // Short low glitch is rejected silently.
    clear_obs();
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(1);
    check("t3_busy_glitch", busy, 1);
    tick(10);
    check("t3_busy_after", busy, 0);
    check("t3_rx", rx_q.size(), 0);
    check("t3_fe", fe_cnt, 0);

    // Low stop bit: frame error, then held in break until the line rises.
    clear_obs();
    send_frame(8'h3C, 1'b0, 1);
    tick(20);
    check("t4_fe", fe_cnt, 1);
    check("t4_busy_break", busy, 1);
    check("t4_tvalid", m_axis_tvalid, 0);
    check("t4_rx", rx_q.size(), 0);
    rxd = 1'b1;
    tick(5);
    check("t4_busy_after", busy, 0);
    check("t4_fe_once", fe_cnt, 1);

    // Overrun with the consumer stalled.
    clear_obs();
    m_axis_tready = 1'b0;
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    tick(10);
    check("t5_ovr", ovr_cnt, 1);
    check("t5_tvalid", m_axis_tvalid, 1);
    check("t5_tdata", m_axis_tdata, 8'h22);
    check("t5_rx_stalled", rx_q.size(), 0);
    m_axis_tready = 1'b1;
    exp_q.push_back(8'h22);
    tick(5);
    compare_stream("t5_data");
    check("t5_tvalid_after", m_axis_tvalid, 0);

    // Reset in the middle of a frame, then a clean frame.
    clear_obs();
    prescale = 16'd1;
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rxd = 8'h96 >> i;
      tick(8);
    end
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    check("t6_tdata", m_axis_tdata, 0);
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_ovr", overrun_error, 0);
    check("t6_fe", frame_error, 0);
    rst = 1'b0;
    tick(10);
    check("t6_busy_idle", busy, 0);
    send_frame(8'h5A, 1'b1, 1);
    exp_q.push_back(8'h5A);
    wait_rx(1, 100);
    compare_stream("t6_data");

    // Random bytes, prescales (including 0) and idle gaps.
    clear_obs();
    for (int f = 0; f < 24; f++) begin
      logic [7:0] b;
      int p;
      b = 8'($urandom);
      p = $urandom_range(0, 3);
      send_frame(b, 1'b1, p);
      exp_q.push_back(b);
      tick($urandom_range(0, 4));
    end
    wait_rx(24, 2000);
    compare_stream("rand_data");
    check("rand_ovr", ovr_cnt, 0);
    check("rand_fe", fe_cnt, 0);
    check("rand_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
